// File: rtl/ahb_lite_sram_slave_pkg.sv
// Shared AHB-Lite types for the SRAM slave: transfer/size/response enums,
// the slave FSM state enum and the byte-lane helper used by the write path.
package ahb_lite_sram_slave_pkg;

  localparam int HTRANS_W = 2;
  localparam int HSIZE_W  = 3;

  // Largest transfer size the SRAM slave supports (word).
  localparam logic [HSIZE_W-1:0] HSIZE_MAX = 3'd2;

  typedef enum logic [HTRANS_W-1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [HSIZE_W-1:0] {
    SIZE_BYTE = 3'd0,
    SIZE_HALF = 3'd1,
    SIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } slave_state_e;

  // Little-endian byte enables for a legal transfer of the given size at the
  // given word offset; anything wider than a word enables nothing.
  function automatic logic [3:0] byte_lanes(input logic [HSIZE_W-1:0] size,
                                            input logic [1:0] offset);
    logic [3:0] lanes;
    lanes = 4'b0000;
    case (size)
      SIZE_BYTE: lanes = 4'b0001 << offset;
      SIZE_HALF: lanes = offset[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: lanes = 4'b1111;
      default:   lanes = 4'b0000;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// DEPTH x 32-bit storage split into four byte lanes, with a byte-enabled
// write port, a combinational read port and a reset that clears every word.
module ahb_sram_array #(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      // Byte lane storage: cleared on reset, written when its enable is set.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            lane_mem[i] <= 8'h00;
          end
        end else if (we && be[gi]) begin
          lane_mem[waddr] <= wdata[8*gi +: 8];
        end
      end

      assign rdata[8*gi +: 8] = lane_mem[raddr];
    end
  endgenerate

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave fronting an internal byte-addressable SRAM. Decodes the
// address phase, inserts WAIT_STATES low cycles per OKAY data phase and
// answers illegal transfers with a two-cycle ERROR response.
module ahb_lite_sram_slave
  import ahb_lite_sram_slave_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                HSEL,
  input  logic [ADDR_W-1:0]   HADDR,
  input  logic [HTRANS_W-1:0] HTRANS,
  input  logic                HWRITE,
  input  logic [HSIZE_W-1:0]  HSIZE,
  input  logic [2:0]          HBURST,
  input  logic [DATA_W-1:0]   HWDATA,
  input  logic                HREADY,
  output logic                HREADYOUT,
  output logic                HRESP,
  output logic [DATA_W-1:0]   HRDATA
);

  localparam int                IDX_W      = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH * 4);
  localparam logic [2:0]        WAIT_INIT  = 3'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  slave_state_e         state_reg, state_next;
  logic [2:0]           cnt_reg, cnt_next;
  logic                 pend_reg, pend_next;
  logic [ADDR_W-1:0]    addr_reg;
  logic                 write_reg;
  logic [HSIZE_W-1:0]   size_reg;

  htrans_e              trans;
  hresp_e               resp;
  logic                 ready;
  logic                 accept;
  logic                 addr_err;
  logic                 data_last;
  logic                 wr_en;
  logic [3:0]           wr_be;
  logic [IDX_W-1:0]     word_idx;
  logic [31:0]          rd_word;

  // Burst type and the address bits above the array never affect the slave.
  logic                 unused_bits;
  assign unused_bits = ^{HBURST, addr_reg[ADDR_W-1:IDX_W+2]};

  assign trans = htrans_e'(HTRANS);
  assign ready = (state_reg == ST_IDLE) || (state_reg == ST_ERR2);

  // Address phase only counts while this slave is ready; with HREADYOUT low
  // the bus holds HREADY low as well, so this gate is a safety net.
  assign accept = HSEL && HREADY && ready &&
                  ((trans == TRANS_NONSEQ) || (trans == TRANS_SEQ));

  assign addr_err = (HADDR >= ADDR_LIMIT) ||
                    (HSIZE > HSIZE_MAX) ||
                    ((HSIZE == SIZE_HALF) && HADDR[0]) ||
                    ((HSIZE == SIZE_WORD) && (HADDR[1:0] != 2'b00));

  // The closing cycle of a legal data phase: memory commits / read data shows.
  assign data_last = pend_reg && ready;
  assign wr_en     = data_last && write_reg;
  assign wr_be     = byte_lanes(size_reg, addr_reg[1:0]);
  assign word_idx  = addr_reg[IDX_W+1:2];

  // State, wait counter and pending flag registers.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 3'd0;
      pend_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pend_reg  <= pend_next;
    end
  end

  // Address-phase controls are captured only when a transfer is accepted.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      addr_reg  <= '0;
      write_reg <= 1'b0;
      size_reg  <= '0;
    end else if (accept) begin
      addr_reg  <= HADDR;
      write_reg <= HWRITE;
      size_reg  <= HSIZE;
    end
  end

  // Next-state logic: accept rules are shared by IDLE and ERR2 so a new
  // transfer can overlap the second ERROR cycle or the last data cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pend_next  = data_last ? 1'b0 : pend_reg;

    case (state_reg)
      ST_IDLE, ST_ERR2: begin
        state_next = ST_IDLE;
        if (accept) begin
          if (addr_err) begin
            state_next = ST_ERR1;
            pend_next  = 1'b0;
          end else if (WAIT_STATES > 0) begin
            state_next = ST_WAIT;
            cnt_next   = WAIT_INIT;
            pend_next  = 1'b1;
          end else begin
            state_next = ST_IDLE;
            pend_next  = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_reg == 3'd0) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      ST_ERR1: begin
        state_next = ST_ERR2;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign resp      = ((state_reg == ST_ERR1) || (state_reg == ST_ERR2)) ? RESP_ERROR : RESP_OKAY;
  assign HRESP     = resp;
  assign HREADYOUT = ready;
  assign HRDATA    = (data_last && !write_reg) ? rd_word : '0;

  ahb_sram_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (HCLK),
    .rst   (HRESET),
    .we    (wr_en),
    .be    (wr_be),
    .waddr (word_idx),
    .wdata (HWDATA),
    .raddr (word_idx),
    .rdata (rd_word)
  );

endmodule
